// File: rtl/bcd_edit_pkg.sv
// Shared types, constants and BCD helpers for the BCD field editor.
// Contents:
//   state_t         editor FSM states {IDLE, EDIT, COMMIT}
//   MIN_MAX_SEC     upper limit of minute/second fields (59)
//   HR24_MAX        upper limit of 24 h hours (23)
//   HR12_MIN/MAX    limits of 12 h hours (01..12)
//   bcd_inc/bcd_dec wrapped single-step BCD arithmetic within [min, max]
//   bcd_ok          range and digit validity check for a loaded field
package bcd_edit_pkg;

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    localparam logic [7:0] MIN_MAX_SEC = 8'h59;
    localparam logic [7:0] HR24_MAX    = 8'h23;
    localparam logic [7:0] HR12_MIN    = 8'h01;
    localparam logic [7:0] HR12_MAX    = 8'h12;

    // Values at or above max wrap to min, so an edit can never leave the range.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] min,
                                           input logic [7:0] max);
        if (val >= max) return min;
        if (val[3:0] == 4'd9) return {val[7:4] + 4'd1, 4'd0};
        return {val[7:4], val[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] val, input logic [7:0] min,
                                           input logic [7:0] max);
        if (val <= min) return max;
        if (val[3:0] == 4'd0) return {val[7:4] - 4'd1, 4'd9};
        return {val[7:4], val[3:0] - 4'd1};
    endfunction

    // Valid BCD digits compare in the same order as their binary encoding.
    function automatic logic bcd_ok(input logic [7:0] val, input logic [7:0] min,
                                    input logic [7:0] max);
        return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val >= min) && (val <= max);
    endfunction

endpackage

// File: rtl/btn_edge_rep.sv
// Pushbutton rising-edge detector with optional hold-to-repeat.
// Configuration: AUTOREPEAT_EN enables the repeat counter; without it HOLD_CYC and
// REP_CYC are unused and only edges produce steps.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   btn    debounced button level
//   clr    clears the repeat counter (release, cursor move, leaving EDIT)
//   step   one-cycle step pulse
module btn_edge_rep #(
    parameter int HOLD_CYC = 50,
    parameter int REP_CYC  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clr,
    output logic step
);

    logic prev_q;
    logic edge_det;

    // Tracks the button in every state, so a button held through load never fires.
    always_ff @(posedge clk) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= btn;
    end

    assign edge_det = btn & ~prev_q;

`ifdef AUTOREPEAT_EN
    logic [15:0] cnt_q;
    logic        held_q;
    logic        rep_fire;

    // cnt_q equals the number of cycles since the edge; after each repeat it is
    // reloaded so that the next repeat lands REP_CYC cycles later.
    assign rep_fire = held_q & btn & (cnt_q == 16'(HOLD_CYC));

    always_ff @(posedge clk) begin
        if (reset || clr || !btn) begin
            cnt_q  <= 16'd0;
            held_q <= 1'b0;
        end else if (edge_det) begin
            cnt_q  <= 16'd1;
            held_q <= 1'b1;
        end else if (rep_fire) begin
            cnt_q  <= 16'(HOLD_CYC - REP_CYC + 1);
        end else if (held_q) begin
            cnt_q  <= cnt_q + 16'd1;
        end
    end

    assign step = edge_det | rep_fire;
`else
    logic unused_cfg;
    assign unused_cfg = clr ^ (HOLD_CYC > 0) ^ (REP_CYC > 0);
    assign step       = edge_det;
`endif

endmodule

// File: rtl/bcd_field_editor.sv
// Editor for NF two-digit BCD fields (field 0 = hours, others 00..59) driven by
// up/down/left/right pushbuttons. Loads the live time on the rising edge of en, pulses
// commit with the edited value on the falling edge.
// Configuration: AUTOREPEAT_EN (see btn_edge_rep) enables hold-to-repeat on up/down.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   en                    edit enable
//   ld_fields, ld_ampm    live values captured at load; field k = [8k+7:8k]
//   fmt12                 1 = 12 h hours, sampled at load
//   bt_up/down/left/right debounced button levels
//   fields, ampm          edited values
//   cursor                selected field
//   editing               high while in EDIT
//   commit                one-cycle pulse with final fields/ampm
//   fixed                 sticky: an invalid loaded field was replaced
module bcd_field_editor
    import bcd_edit_pkg::*;
#(
    parameter int  NF       = 3,
    parameter int  HOLD_CYC = 50,
    parameter int  REP_CYC  = 10,
    localparam int CW       = $clog2(NF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [NF*8-1:0] ld_fields,
    input  logic            ld_ampm,
    input  logic            fmt12,
    input  logic            bt_up,
    input  logic            bt_down,
    input  logic            bt_left,
    input  logic            bt_right,
    output logic [NF*8-1:0] fields,
    output logic            ampm,
    output logic [CW-1:0]   cursor,
    output logic            editing,
    output logic            commit,
    output logic            fixed
);

    state_t          state_q, state_d;
    logic [NF*8-1:0] fields_q, fields_d;
    logic            ampm_q, ampm_d;
    logic [CW-1:0]   cursor_q, cursor_d;
    logic            fmt12_q, fmt12_d;
    logic            fixed_q, fixed_d;

    logic up_p, down_p, left_p, right_p;
    logic in_edit, do_up, do_down, do_left, do_right, rep_clr;
    logic [7:0] sel, lo, hi, stepped, ld_val, ld_lo, ld_hi;

    assign in_edit  = (state_q == EDIT) & en;
    assign do_up    = in_edit & up_p & ~down_p;
    assign do_down  = in_edit & down_p & ~up_p;
    assign do_left  = in_edit & left_p & ~right_p;
    assign do_right = in_edit & right_p & ~left_p;
    assign rep_clr  = (state_q != EDIT) | do_left | do_right;

    btn_edge_rep #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_up (
        .clk(clk), .reset(reset), .btn(bt_up), .clr(rep_clr), .step(up_p)
    );
    btn_edge_rep #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_down (
        .clk(clk), .reset(reset), .btn(bt_down), .clr(rep_clr), .step(down_p)
    );
    // Cursor buttons never repeat: their counters are held clear.
    btn_edge_rep #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_left (
        .clk(clk), .reset(reset), .btn(bt_left), .clr(1'b1), .step(left_p)
    );
    btn_edge_rep #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_right (
        .clk(clk), .reset(reset), .btn(bt_right), .clr(1'b1), .step(right_p)
    );

    always_comb begin
        state_d  = state_q;
        fields_d = fields_q;
        ampm_d   = ampm_q;
        cursor_d = cursor_q;
        fmt12_d  = fmt12_q;
        fixed_d  = fixed_q;
        sel      = 8'h00;
        ld_val   = 8'h00;
        ld_lo    = 8'h00;
        ld_hi    = 8'h00;

        for (int k = 0; k < NF; k++) begin
            if (cursor_q == CW'(k)) sel = fields_q[8*k +: 8];
        end

        if (cursor_q != '0) begin
            lo = 8'h00;
            hi = MIN_MAX_SEC;
        end else if (fmt12_q) begin
            lo = HR12_MIN;
            hi = HR12_MAX;
        end else begin
            lo = 8'h00;
            hi = HR24_MAX;
        end
        stepped = do_up ? bcd_inc(sel, lo, hi) : bcd_dec(sel, lo, hi);

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = EDIT;
                    cursor_d = '0;
                    fixed_d  = 1'b0;
                    fmt12_d  = fmt12;
                    ampm_d   = ld_ampm;
                    for (int k = 0; k < NF; k++) begin
                        ld_val = ld_fields[8*k +: 8];
                        if (k != 0) begin
                            ld_lo = 8'h00;
                            ld_hi = MIN_MAX_SEC;
                        end else if (fmt12) begin
                            ld_lo = HR12_MIN;
                            ld_hi = HR12_MAX;
                        end else begin
                            ld_lo = 8'h00;
                            ld_hi = HR24_MAX;
                        end
                        if (bcd_ok(ld_val, ld_lo, ld_hi)) begin
                            fields_d[8*k +: 8] = ld_val;
                        end else begin
                            fields_d[8*k +: 8] = ld_lo;
                            fixed_d            = 1'b1;
                        end
                    end
                end
            end
            EDIT: begin
                if (!en) begin
                    state_d = COMMIT;
                end else begin
                    // The step targets the cursor as it was before any move this cycle.
                    if (do_up || do_down) begin
                        for (int k = 0; k < NF; k++) begin
                            if (cursor_q == CW'(k)) fields_d[8*k +: 8] = stepped;
                        end
                        if (cursor_q == '0 && fmt12_q &&
                            ((do_up && sel == 8'h11) || (do_down && sel == HR12_MAX))) begin
                            ampm_d = ~ampm_q;
                        end
                    end
                    if (do_right) begin
                        cursor_d = (cursor_q == CW'(NF - 1)) ? '0 : cursor_q + 1'b1;
                    end else if (do_left) begin
                        cursor_d = (cursor_q == '0) ? CW'(NF - 1) : cursor_q - 1'b1;
                    end
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            fields_q <= '0;
            ampm_q   <= 1'b0;
            cursor_q <= '0;
            fmt12_q  <= 1'b0;
            fixed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fields_q <= fields_d;
            ampm_q   <= ampm_d;
            cursor_q <= cursor_d;
            fmt12_q  <= fmt12_d;
            fixed_q  <= fixed_d;
        end
    end

    assign fields  = fields_q;
    assign ampm    = ampm_q;
    assign cursor  = cursor_q;
    assign fixed   = fixed_q;
    assign editing = (state_q == EDIT);
    assign commit  = (state_q == COMMIT);

endmodule

// File: tb/tb_bcd_field_editor.sv
module tb_bcd_field_editor;

    localparam int NF = 3;

    logic        clk = 1'b0;
    logic        reset, en, ld_ampm, fmt12;
    logic [23:0] ld_fields;
    logic        bt_up, bt_down, bt_left, bt_right;
    logic [23:0] fields;
    logic        ampm, editing, commit, fixed;
    logic [1:0]  cursor;

    int n_cmp = 0;
    int n_err = 0;

    bcd_field_editor #(.NF(NF), .HOLD_CYC(5), .REP_CYC(2)) dut (
        .clk(clk), .reset(reset), .en(en), .ld_fields(ld_fields), .ld_ampm(ld_ampm),
        .fmt12(fmt12), .bt_up(bt_up), .bt_down(bt_down), .bt_left(bt_left),
        .bt_right(bt_right), .fields(fields), .ampm(ampm), .cursor(cursor),
        .editing(editing), .commit(commit), .fixed(fixed)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        f12;
        logic [23:0] ld;
        logic        am;
        int          rights;
        int          btn;   // 0 none, 1 up, 2 down
        logic [23:0] ef;
        logic        eam;
        logic        efix;
    } vec_t;

    typedef struct {
        string       name;
        logic [23:0] f;
        logic        am;
        logic [1:0]  cur;
        logic        ed;
        logic        fx;
        logic        cm;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];

    task automatic addv(input string name, input logic f12, input logic [23:0] ld,
                        input logic am, input int rights, input int btn,
                        input logic [23:0] ef, input logic eam, input logic efix);
        vec_t v;
        v.name = name; v.f12 = f12; v.ld = ld; v.am = am; v.rights = rights;
        v.btn = btn; v.ef = ef; v.eam = eam; v.efix = efix;
        vq.push_back(v);
    endtask

    task automatic expect_out(input string name, input logic [23:0] f, input logic am,
                              input logic [1:0] cur, input logic ed, input logic fx,
                              input logic cm);
        exp_t e;
        e.name = name; e.f = f; e.am = am; e.cur = cur; e.ed = ed; e.fx = fx; e.cm = cm;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".fields"}, 32'(fields), 32'(e.f));
        chk({e.name, ".ampm"}, 32'(ampm), 32'(e.am));
        chk({e.name, ".cursor"}, 32'(cursor), 32'(e.cur));
        chk({e.name, ".editing"}, 32'(editing), 32'(e.ed));
        chk({e.name, ".fixed"}, 32'(fixed), 32'(e.fx));
        chk({e.name, ".commit"}, 32'(commit), 32'(e.cm));
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r);
        bt_up = u; bt_down = d; bt_left = l; bt_right = r;
        @(negedge clk);
        bt_up = 1'b0; bt_down = 1'b0; bt_left = 1'b0; bt_right = 1'b0;
        @(negedge clk);
    endtask

    task automatic load(input logic f12, input logic [23:0] ld, input logic am);
        fmt12 = f12; ld_fields = ld; ld_ampm = am; en = 1'b1;
        @(negedge clk);
    endtask

    task automatic finish_edit();
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; ld_ampm = 1'b0; fmt12 = 1'b0; ld_fields = '0;
        bt_up = 1'b0; bt_down = 1'b0; bt_left = 1'b0; bt_right = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_out("reset", 24'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_out();

        addv("hr24_23_up",   1'b0, 24'h585923, 1'b1, 0, 1, 24'h585900, 1'b1, 1'b0);
        addv("hr12_11_up",   1'b1, 24'h003011, 1'b0, 0, 1, 24'h003012, 1'b1, 1'b0);
        addv("hr12_12_up",   1'b1, 24'h003012, 1'b1, 0, 1, 24'h003001, 1'b1, 1'b0);
        addv("hr12_01_down", 1'b1, 24'h003001, 1'b1, 0, 2, 24'h003012, 1'b1, 1'b0);
        addv("hr12_12_down", 1'b1, 24'h003012, 1'b1, 0, 2, 24'h003011, 1'b0, 1'b0);
        addv("hr12_09_up",   1'b1, 24'h000009, 1'b0, 0, 1, 24'h000010, 1'b0, 1'b0);
        addv("sec_00_down",  1'b0, 24'h001508, 1'b0, 2, 2, 24'h591508, 1'b0, 1'b0);
        addv("min_59_up",    1'b0, 24'h005908, 1'b0, 1, 1, 24'h000008, 1'b0, 1'b0);
        addv("min_carry",    1'b0, 24'h000908, 1'b0, 1, 1, 24'h001008, 1'b0, 1'b0);
        addv("sec_borrow",   1'b0, 24'h400908, 1'b0, 2, 2, 24'h390908, 1'b0, 1'b0);
        addv("hr24_00_down", 1'b0, 24'h000000, 1'b0, 0, 2, 24'h000023, 1'b0, 1'b0);
        addv("fix_nonbcd",   1'b0, 24'h007A05, 1'b0, 0, 0, 24'h000005, 1'b0, 1'b1);
        addv("fix_hr12_00",  1'b1, 24'h102000, 1'b0, 0, 0, 24'h102001, 1'b0, 1'b1);
        addv("fix_hr24_24",  1'b0, 24'h106024, 1'b0, 0, 0, 24'h100000, 1'b0, 1'b1);

        foreach (vq[i]) begin
            load(vq[i].f12, vq[i].ld, vq[i].am);
            for (int r = 0; r < vq[i].rights; r++) press(1'b0, 1'b0, 1'b0, 1'b1);
            if (vq[i].btn == 1) press(1'b1, 1'b0, 1'b0, 1'b0);
            if (vq[i].btn == 2) press(1'b0, 1'b1, 1'b0, 1'b0);
            expect_out(vq[i].name, vq[i].ef, vq[i].eam, 2'(vq[i].rights), 1'b1,
                       vq[i].efix, 1'b0);
            check_out();
            finish_edit();
        end

        // 12 h sequence through the AM/PM boundary in both directions.
        load(1'b1, 24'h003011, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("seq12_up1", 24'h003012, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0); check_out();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("seq12_up2", 24'h003001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0); check_out();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("seq12_dn1", 24'h003012, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0); check_out();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("seq12_dn2", 24'h003011, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); check_out();
        finish_edit();

        // Cursor wrap, conflicting buttons, and step with simultaneous move.
        load(1'b0, 24'h000005, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("cur_left", 24'h000005, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0); check_out();
        press(1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("cur_right", 24'h000005, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); check_out();
        press(1'b0, 1'b0, 1'b1, 1'b1);
        expect_out("cur_both", 24'h000005, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); check_out();
        press(1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("updown_both", 24'h000005, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); check_out();
        press(1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("step_and_move", 24'h000006, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0); check_out();
        finish_edit();

        // Edit to 10:20:30 and commit; then buttons in IDLE are ignored.
        load(1'b0, 24'h302009, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        @(negedge clk);
        expect_out("commit_pulse", 24'h302010, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1); check_out();
        @(negedge clk);
        expect_out("commit_end", 24'h302010, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); check_out();
        press(1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("idle_ignore", 24'h302010, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); check_out();

        // Reset mid-edit discards everything and never commits.
        load(1'b0, 24'h112213, 1'b1);
        press(1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b1; en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            expect_out("reset_mid", 24'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); check_out();
            @(negedge clk);
        end

        // A button held through load must not step.
        bt_up = 1'b1;
        repeat (2) @(negedge clk);
        load(1'b0, 24'h000005, 1'b0);
        repeat (2) @(negedge clk);
        expect_out("held_thru_load", 24'h000005, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); check_out();
        bt_up = 1'b0;
        @(negedge clk);
        finish_edit();

        // Hold up on minutes 00: edge step, repeats at edge+5, +7, +9 (11 held cycles).
        load(1'b0, 24'h000005, 1'b0);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        bt_up = 1'b1;
        repeat (11) @(negedge clk);
        bt_up = 1'b0;
        @(negedge clk);
`ifdef AUTOREPEAT_EN
        expect_out("hold_repeat", 24'h000405, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
`else
        expect_out("hold_repeat", 24'h000105, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
`endif
        check_out();
        finish_edit();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
